// File: rtl/pipelined_magnitude_comparator.sv
// pipelined_magnitude_comparator: valid/ready pipelined, cascadable, signed/unsigned A-vs-B magnitude compare
// Parameters: WIDTH operand bits, CHUNK bits resolved per stage; depth/latency STAGES = ceil(WIDTH/CHUNK)
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready      input handshake; in_ready drops only while the output is stalled
//   a, b                     operands
//   signed_mode              1 = two's-complement compare, 0 = unsigned
//   lt_in, eq_in, gt_in      cascade triple reported when a == b, captured at accept
//   out_valid / out_ready    output handshake
//   lt, eq, gt               one-hot result, all zero while out_valid is low
module pipelined_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             lt_in,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int C0 = WIDTH - CHUNK * (STAGES - 1);
    logic stall;
    logic [WIDTH-1:0] af, bf;
    // flipping the sign bit turns a two's-complement order into an unsigned one
    assign af = a ^ (WIDTH'(signed_mode) << (WIDTH - 1));
    assign bf = b ^ (WIDTH'(signed_mode) << (WIDTH - 1));
    for (genvar k = 0; k < STAGES; k++) begin : g
        localparam int SW = (k == 0) ? C0 : CHUNK;
        // bits still unresolved after this stage; the stage keeps only those
        localparam int RW = WIDTH - C0 - k * CHUNK;
        logic [RW+SW-1:0] src_a, src_b;
        logic [SW-1:0] sa, sb;
        logic pv, pd, prl, prg;
        logic [2:0] pc;
        logic v, d, rl, rg;
        logic [2:0] c;
        if (k == 0) begin : src
            assign src_a = af;
            assign src_b = bf;
            assign pv = in_valid;
            assign pd = 1'b0;
            assign prl = 1'b0;
            assign prg = 1'b0;
            assign pc = {lt_in, eq_in, gt_in};
        end else begin : src
            assign src_a = g[k-1].rem.ra;
            assign src_b = g[k-1].rem.rb;
            assign pv = g[k-1].v;
            assign pd = g[k-1].d;
            assign prl = g[k-1].rl;
            assign prg = g[k-1].rg;
            assign pc = g[k-1].c;
        end
        assign sa = src_a[RW+SW-1 -: SW];
        assign sb = src_b[RW+SW-1 -: SW];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v  <= 1'b0;
                d  <= 1'b0;
                rl <= 1'b0;
                rg <= 1'b0;
                c  <= 3'b000;
            end else if (!stall) begin
                v  <= pv;
                d  <= pd | (sa != sb);
                rl <= pd ? prl : (sa < sb);
                rg <= pd ? prg : (sa > sb);
                c  <= pc;
            end
        end
        if (RW > 0) begin : rem
            logic [RW-1:0] ra, rb;
            always_ff @(posedge clk) begin
                if (!stall) begin
                    ra <= src_a[RW-1:0];
                    rb <= src_b[RW-1:0];
                end
            end
        end
    end
    assign out_valid = g[STAGES-1].v;
    assign stall = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign lt = out_valid & (g[STAGES-1].d ? g[STAGES-1].rl : g[STAGES-1].c[2]);
    assign eq = out_valid & ~g[STAGES-1].d & g[STAGES-1].c[1];
    assign gt = out_valid & (g[STAGES-1].d ? g[STAGES-1].rg : g[STAGES-1].c[0]);
endmodule

// File: tb/tb_pipelined_magnitude_comparator.sv
// tb_pipelined_magnitude_comparator: directed checks of an 8/3 (3-stage) and a 16/16 (1-stage) comparator
module tb_pipelined_magnitude_comparator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic in_valid, in_ready, sm, lti, eqi, gti, out_valid, out_ready, lt, eq, gt;
    logic [7:0] a, b;
    logic in_valid2, in_ready2, sm2, out_valid2, lt2, eq2, gt2;
    logic [15:0] a2, b2;
    pipelined_magnitude_comparator #(.WIDTH(8), .CHUNK(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .signed_mode(sm), .lt_in(lti), .eq_in(eqi), .gt_in(gti), .out_valid(out_valid),
        .out_ready(out_ready), .lt(lt), .eq(eq), .gt(gt)
    );
    pipelined_magnitude_comparator #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .signed_mode(sm2), .lt_in(1'b0), .eq_in(1'b1), .gt_in(1'b0), .out_valid(out_valid2),
        .out_ready(1'b1), .lt(lt2), .eq(eq2), .gt(gt2)
    );
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [2:0] cas;
        logic [2:0] res;
    } vec_t;
    vec_t tv [13];
    int n_cmp = 0;
    int n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic send(input vec_t t);
        @(negedge clk);
        in_valid = 1'b1;
        a = t.a;
        b = t.b;
        sm = t.sm;
        {lti, eqi, gti} = t.cas;
    endtask
    task automatic run_vec(input vec_t t, input int i);
        send(t);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_lat1", i), out_valid, 0);
        @(negedge clk);
        chk($sformatf("vec%0d_lat2", i), out_valid, 0);
        @(negedge clk);
        chk($sformatf("vec%0d_valid", i), out_valid, 1);
        chk($sformatf("vec%0d_res", i), {lt, eq, gt}, t.res);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        int idx, got, stall_n;
        tv[0]  = '{8'hA5, 8'h5A, 1'b0, 3'b010, 3'b001};
        tv[1]  = '{8'h80, 8'h7F, 1'b1, 3'b010, 3'b100};
        tv[2]  = '{8'h80, 8'h7F, 1'b0, 3'b010, 3'b001};
        tv[3]  = '{8'h3C, 8'h3C, 1'b0, 3'b100, 3'b100};
        tv[4]  = '{8'h3C, 8'h3C, 1'b0, 3'b010, 3'b010};
        tv[5]  = '{8'h3C, 8'h3C, 1'b0, 3'b001, 3'b001};
        tv[6]  = '{8'h01, 8'h00, 1'b0, 3'b010, 3'b001};
        tv[7]  = '{8'h00, 8'h01, 1'b1, 3'b010, 3'b100};
        tv[8]  = '{8'hFF, 8'hFE, 1'b1, 3'b010, 3'b001};
        tv[9]  = '{8'h3C, 8'h3C, 1'b1, 3'b101, 3'b101};
        tv[10] = '{8'h40, 8'h41, 1'b0, 3'b010, 3'b100};
        tv[11] = '{8'h7F, 8'h80, 1'b1, 3'b010, 3'b001};
        tv[12] = '{8'hA5, 8'h5A, 1'b0, 3'b100, 3'b001};
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sm = 1'b0; lti = 1'b0; eqi = 1'b1; gti = 1'b0;
        out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; sm2 = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_res", {lt, eq, gt}, 0);
        chk("reset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) run_vec(tv[i], i);
        // back-to-back: results on consecutive cycles in issue order
        send(tv[1]);
        send(tv[2]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_first_valid", out_valid, 1);
        chk("b2b_first_res", {lt, eq, gt}, tv[1].res);
        @(negedge clk);
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_res", {lt, eq, gt}, tv[2].res);
        @(negedge clk);
        chk("b2b_drained", out_valid, 0);
        // 5-deep stream with a 6-cycle downstream stall once the first result shows up
        idx = 0; got = 0; stall_n = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            if (out_valid && stall_n < 6) begin
                out_ready = 1'b0;
                stall_n++;
            end else out_ready = 1'b1;
            #1;
            if (out_valid) begin
                chk($sformatf("stream_res%0d", got), {lt, eq, gt}, tv[got].res);
                if (!out_ready) chk("stall_in_ready", in_ready, 0);
                else got++;
            end
            in_valid = (idx < 5);
            if (idx < 5) begin
                a = tv[idx].a; b = tv[idx].b; sm = tv[idx].sm; {lti, eqi, gti} = tv[idx].cas;
            end
            #1;
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_delivered", got, 5);
        chk("stream_accepted", idx, 5);
        chk("stream_stall_cycles", stall_n, 6);
        @(negedge clk);
        chk("stream_no_extra", out_valid, 0);
        // async reset with a result on the output and two more in flight
        send(tv[0]);
        send(tv[1]);
        send(tv[2]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("prereset_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_res", {lt, eq, gt}, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("no_stale%0d", i), out_valid, 0);
        end
        run_vec(tv[3], 100);
        // single-stage instance: latency 1
        @(negedge clk);
        in_valid2 = 1'b1; a2 = 16'hFFFF; b2 = 16'h0001; sm2 = 1'b1;
        @(negedge clk);
        chk("single_signed_valid", out_valid2, 1);
        chk("single_signed_res", {lt2, eq2, gt2}, 3'b100);
        sm2 = 1'b0;
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("single_unsigned_valid", out_valid2, 1);
        chk("single_unsigned_res", {lt2, eq2, gt2}, 3'b001);
        @(negedge clk);
        chk("single_drained", out_valid2, 0);
        chk("single_in_ready", in_ready2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_magnitude_comparator.md
Name: pipelined_magnitude_comparator

Overview:
- Parametrised, pipelined, cascadable magnitude comparator. Compares A and B one CHUNK-bit slice per stage, MSB slice first.
- Produces one-hot lt/eq/gt with valid/ready flow control.
- Supports signed and unsigned compare per transaction.
- Cascade inputs lt_in/eq_in/gt_in resolve the all-equal case, so instances can be chained for wider words. Used in sort networks and threshold checks.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 1.
- CHUNK, 4, bits resolved per pipeline stage; 1 <= CHUNK <= WIDTH.
- Derived: STAGES = ceil(WIDTH/CHUNK). This is the pipeline depth and the latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned compare.
- lt_in  in  1  cascade result used when a == b.
- eq_in  in  1  cascade result used when a == b.
- gt_in  in  1  cascade result used when a == b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- lt  out  1  A < B (or cascaded).
- eq  out  1  A == B and eq_in.
- gt  out  1  A > B (or cascaded).

Behaviour:
- Reset: asynchronous. Immediately clears every stage valid bit, out_valid, lt, eq and gt to 0. All in-flight transactions are discarded. in_ready = 1 while rst is high and after it deasserts.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output completes when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, every stage register holds its value. out_valid, lt, eq and gt stay stable until accepted.
  - Accept and drain in the same cycle are permitted. Full throughput is one transaction per cycle.
- Latency: a transaction accepted at edge n appears on out_valid after edge n+STAGES-1 (STAGES registered stages), absent stalls. Order is preserved and no transaction is dropped or duplicated.
- Signed handling: when signed_mode = 1, bit WIDTH-1 of both a and b is inverted before slicing, then the compare is unsigned. signed_mode travels with the transaction.
- Slicing:
  - Stage 0 handles bits [WIDTH-1 : WIDTH-CHUNK'], where CHUNK' = WIDTH - CHUNK*(STAGES-1) and 1 <= CHUNK' <= CHUNK. The top slice may be narrower than CHUNK.
  - Stage k (k >= 1) handles the next CHUNK bits downward.
- Per-stage state: valid, decided, res_lt, res_gt, the remaining unresolved bits of A and B, and the cascade triple.
- Stage rule:
  - If decided is already set, pass the state through unchanged.
  - Otherwise, if slice_a > slice_b: set decided and res_gt.
  - If slice_a < slice_b: set decided and res_lt.
  - Otherwise leave decided = 0.
- Final stage output:
  - If decided: lt = res_lt, gt = res_gt, eq = 0.
  - Else: lt = lt_in, eq = eq_in, gt = gt_in, as captured at accept time.
- Cascade triple:
  - The cascade triple is captured at accept time, not sampled at output.
  - lt_in, eq_in and gt_in are expected to be one-hot. A non-one-hot triple is passed through unchanged, with no correction or error.
  - For standalone use, tie eq_in = 1 and lt_in = gt_in = 0.
- Outputs lt, eq and gt are 0 whenever out_valid = 0.
- WIDTH == CHUNK: single stage, latency 1.

Test Plan:
- WIDTH=8, CHUNK=3, unsigned; a=8'hA5, b=8'h5A, eq_in=1 -> out_valid exactly 3 cycles after accept, with gt=1, lt=0, eq=0.
- WIDTH=8, CHUNK=3; a=8'h80, b=8'h7F. With signed_mode=1 -> lt=1. Same operands with signed_mode=0 -> gt=1. Back-to-back issue must show results in order on consecutive cycles.
- a=b=8'h3C. Cascade lt_in=1 -> lt=1. Cascade eq_in=1 -> eq=1. Cascade gt_in=1 -> gt=1. Differ only in LSB (a=8'h01, b=8'h00) -> gt=1.
- Stream 5 transactions back-to-back, holding out_ready=0 for 6 cycles once the first result appears -> in_ready=0 during the stall, outputs held stable, then all 5 results delivered in order with none lost.
- Assert rst for 1 cycle with 2 transactions in flight -> out_valid, lt, eq and gt go to 0 without a clock edge. No stale result emerges afterward, and the next accepted transaction completes with correct latency.
- WIDTH=16, CHUNK=16 (single stage); a=16'hFFFF, b=16'h0001, signed_mode=1 -> lt=1 after 1 cycle.
